// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and presents it to decode.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    HALTED
`ifdef IFU_MISALIGN_CHECK_EN
    , FAULT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  // Only one request is ever outstanding, so the PC register doubles as the request address.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          if (halt) begin
            state_d = HALTED;
          end else if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
              state_d = FAULT;
            end else begin
              pc_d    = redirect_pc;
              state_d = FETCH;
            end
`else
            pc_d    = redirect_pc & ~32'h3;
            state_d = FETCH;
`endif
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == FETCH);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

`ifdef IFU_MISALIGN_CHECK_EN
  // FAULT is only left through reset, so decoding it from the state register makes fault sticky.
  assign fault = (state_q == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the fetch protocol.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;

  inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount;
  int failCount;

  // Model of the fetch protocol: what has been asked for, what is pending and what is on offer.
  logic        mIdle;
  logic        mInFlight;
  logic        mHave;
  logic        mHalted;
  logic        mFaulted;
  logic [31:0] mPc;
  logic [31:0] mInst;
  logic [31:0] mInstPc;
  int          cycleNo;
  int          acceptCyc[$];
  logic [31:0] acceptAddr[$];
  bit          fixedMem;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at time %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic expReq();
    return !mIdle && !mInFlight && !mHave && !mHalted && !mFaulted;
  endfunction

  task automatic modelReset();
    mIdle     = 1'b1;
    mInFlight = 1'b0;
    mHave     = 1'b0;
    mHalted   = 1'b0;
    mFaulted  = 1'b0;
    mPc       = RESET_PC;
    mInst     = '0;
    mInstPc   = '0;
    cycleNo   = 0;
    acceptCyc.delete();
    acceptAddr.delete();
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, ".reqValid"}, imem_req_valid, 0);
    checkOutput({phase, ".reqAddr"}, imem_req_addr, RESET_PC);
    checkOutput({phase, ".instValid"}, inst_valid, 0);
    checkOutput({phase, ".inst"}, inst, 0);
    checkOutput({phase, ".instPc"}, inst_pc, 0);
    checkOutput({phase, ".fault"}, fault, 0);
  endtask

  // Reset is raised mid-cycle so the asynchronous clear can be observed before any clock edge.
  task automatic doReset(input bit checkAsync);
    rst = 1'b1;
    #1;
    if (checkAsync) checkResetValues("rstAsync");
    @(posedge clk);
    #1;
    checkResetValues("rstHeld");
    rst = 1'b0;
    modelReset();
    #1;
    checkResetValues("rstRelease");
  endtask

  task automatic checkAll();
    checkOutput("reqValid", imem_req_valid, expReq());
    if (expReq()) checkOutput("reqAddr", imem_req_addr, mPc);
    checkOutput("instValid", inst_valid, mHave);
    if (mHave) begin
      checkOutput("inst", inst, mInst);
      checkOutput("instPc", inst_pc, mInstPc);
    end
    checkOutput("fault", fault, mFaulted);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks the outputs.
  task automatic applyStimulus(input logic rdy, input logic rspV, input logic [31:0] rspD,
                               input logic instRdy, input logic redV, input logic [31:0] redPc,
                               input logic haltIn);
    logic        fetching;
    logic        dutReq;
    logic [31:0] dutAddr;
    imem_req_ready = rdy;
    imem_rsp_valid = rspV;
    imem_rsp_data  = rspD;
    inst_ready     = instRdy;
    redirect_valid = redV;
    redirect_pc    = redPc;
    halt           = haltIn;
    fetching = expReq();
    dutReq   = imem_req_valid;
    dutAddr  = imem_req_addr;
    @(posedge clk);
    if (dutReq && rdy) begin
      acceptCyc.push_back(cycleNo);
      acceptAddr.push_back(dutAddr);
    end
    if (mIdle) begin
      mIdle = 1'b0;
    end else if (fetching) begin
      if (rdy) mInFlight = 1'b1;
    end else if (mInFlight) begin
      if (rspV) begin
        mInFlight = 1'b0;
        mHave     = 1'b1;
        mInst     = rspD;
        mInstPc   = mPc;
      end
    end else if (mHave && instRdy) begin
      mHave = 1'b0;
      if (haltIn) begin
        mHalted = 1'b1;
      end else if (redV) begin
`ifdef IFU_MISALIGN_CHECK_EN
        if (redPc % 4 != 0) mFaulted = 1'b1;
        else mPc = redPc;
`else
        mPc = redPc - (redPc % 4);
`endif
      end else begin
        mPc = mPc + 32'd4;
      end
    end
    cycleNo++;
    #1;
    checkAll();
  endtask

  // Percentages control memory readiness, response latency and decode back-pressure.
  task automatic autoCycle(input int rdyPct, input int rspPct, input int useRdyPct, input logic redV,
                           input logic [31:0] redPc, input logic haltIn, input int spurPct);
    logic        rspV;
    logic [31:0] data;
    rspV = mInFlight ? ($urandom_range(99) < rspPct) : ($urandom_range(99) < spurPct);
    data = fixedMem ? 32'h0000_0013 : $urandom;
    applyStimulus($urandom_range(99) < rdyPct, rspV, data, $urandom_range(99) < useRdyPct,
                  redV, redPc, haltIn);
  endtask

  task automatic runUntilHave(input int maxCycles);
    for (int i = 0; i < maxCycles && !inst_valid; i++) autoCycle(100, 100, 0, 0, 32'h0, 0, 0);
    checkOutput("reachHold", inst_valid, 1);
  endtask

  int          quietCount;
  logic [31:0] rp;

  initial begin
    assertCount    = 0;
    failCount      = 0;
    fixedMem       = 1'b1;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    modelReset();

    // Back-to-back fetch with an always-ready memory and decoder.
    doReset(0);
    repeat (9) autoCycle(100, 100, 100, 0, 32'h0, 0, 0);
    checkOutput("tputCount", acceptCyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < acceptCyc.size()) begin
        checkOutput("tputCycle", acceptCyc[i], 1 + 3 * i);
        checkOutput("tputAddr", acceptAddr[i], RESET_PC + 4 * i);
      end
    end

    // Memory stalls the first request, then decode stalls the delivered instruction.
    doReset(0);
    repeat (6) autoCycle(0, 100, 100, 0, 32'h0, 0, 0);
    autoCycle(100, 100, 0, 0, 32'h0, 0, 0);
    checkOutput("stallAccepts", acceptCyc.size(), 1);
    if (acceptCyc.size() > 0) checkOutput("stallAcceptCycle", acceptCyc[0], 6);
    autoCycle(100, 100, 0, 0, 32'h0, 0, 0);
    checkOutput("singleWait", inst_valid, 1);
    repeat (4) autoCycle(100, 100, 0, 0, 32'h0, 0, 0);
    autoCycle(100, 100, 100, 1, 32'h8000_0100, 0, 0);
    checkOutput("redirAddr", imem_req_addr, 32'h8000_0100);

    // Redirect and halt pulsed while waiting for memory must be ignored.
    autoCycle(100, 0, 0, 0, 32'h0, 0, 0);
    autoCycle(100, 0, 0, 1, 32'h9000_0000, 1, 0);
    autoCycle(100, 100, 0, 0, 32'h0, 0, 0);
    autoCycle(100, 100, 100, 0, 32'h0, 0, 0);
    checkOutput("ignoreRedirAddr", imem_req_addr, 32'h8000_0104);

    // Halt wins over a simultaneous redirect and stops all fetching.
    runUntilHave(10);
    autoCycle(100, 100, 100, 1, 32'h8000_0200, 1, 0);
    quietCount = 0;
    repeat (20) begin
      autoCycle(100, 100, 100, 1, $urandom, 0, 50);
      quietCount += imem_req_valid + inst_valid;
    end
    checkOutput("haltQuiet", quietCount, 0);

    // Misaligned redirect target.
    doReset(0);
    runUntilHave(10);
    autoCycle(100, 100, 100, 1, 32'h8000_0102, 0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("faultSet", fault, 1);
    quietCount = 0;
    repeat (5) begin
      autoCycle(100, 100, 100, 0, 32'h0, 0, 30);
      quietCount += imem_req_valid + inst_valid;
    end
    checkOutput("faultQuiet", quietCount, 0);
`else
    checkOutput("alignAddr", imem_req_addr, 32'h8000_0100);
`endif

    // PC+4 wraps at the top of the address space; reset then lands during HOLD.
    doReset(0);
    runUntilHave(10);
    autoCycle(100, 100, 100, 1, 32'hFFFF_FFFC, 0, 0);
    runUntilHave(10);
    autoCycle(100, 100, 100, 0, 32'h0, 0, 0);
    checkOutput("wrapAddr", imem_req_addr, 32'h0000_0000);
    runUntilHave(10);
    doReset(1);

    // Reset while a request is in flight restarts cleanly from the reset PC.
    autoCycle(100, 0, 0, 0, 32'h0, 0, 0);
    autoCycle(100, 0, 0, 0, 32'h0, 0, 0);
    doReset(1);
    autoCycle(100, 100, 100, 0, 32'h0, 0, 0);
    checkOutput("postResetReq", imem_req_valid, 1);
    checkOutput("postResetAddr", imem_req_addr, RESET_PC);

    // Randomized traffic with variable latency, back-pressure, stray responses and resets.
    fixedMem = 1'b0;
    doReset(0);
    for (int c = 0; c < 2000; c++) begin
      rp = RESET_PC + $urandom_range(0, 4095);
      if ($urandom_range(1) == 0) rp = rp & 32'hFFFF_FFFC;
      if (((mHalted || mFaulted) && $urandom_range(9) == 0) || $urandom_range(299) == 0)
        doReset($urandom_range(1) == 1);
      else
        autoCycle(70, 60, 60, $urandom_range(2) == 0, rp, $urandom_range(15) == 0, 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit for the single-cycle NPC core: owns the PC, issues word reads to instruction memory over a valid/ready request channel, and presents one fetched instruction at a time, with its PC, to the decode/control stage. It is the producing end of the `inst` interface that the control decoder consumes. It advances on consume, taking either PC+4 or a redirect target from the jump path. It stops fetching when the core signals halt (ebreak).

## Interface
- `RESET_PC`, default 32'h8000_0000, PC of the first fetch after reset.
- `clk`  in  1  core clock; one clock only; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word address (byte address, bits [1:0]=0).
- `imem_rsp_valid`  in  1  read data valid (one pulse per accepted request).
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a fetched instruction.
- `inst_ready`  in  1  decode/execute consumes the instruction this cycle.
- `inst`  out  32  instruction to decoder.
- `inst_pc`  out  32  PC of `inst`.
- `redirect_valid`  in  1  taken jump (jal/jalr); sampled only on consume.
- `redirect_pc`  in  32  jump target.
- `halt`  in  1  current instruction is ebreak; sampled only on consume.
- `fault`  out  1  misaligned target detected (only with `IFU_MISALIGN_CHECK_EN`; otherwise tied 0).

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALTED, FAULT.
- IDLE: reset state; unconditionally → FETCH next cycle.
- FETCH: `imem_req_valid`=1, `imem_req_addr`=pc. On `imem_req_valid && imem_req_ready` → WAIT. Address stays stable while not accepted.
- WAIT: on `imem_rsp_valid`, capture `imem_rsp_data` into inst register and latch `inst_pc`=pc, then → HOLD. `imem_rsp_valid` in any other state is ignored.
- HOLD: `inst_valid`=1; `inst`, `inst_pc` stable until consumed. Consume = `inst_valid && inst_ready`. On consume:
  - `halt`=1 → HALTED; pc unchanged. Halt has priority over redirect.
  - else `redirect_valid`=1 → pc = redirect target, → FETCH.
  - else pc = pc+4 (32-bit, wraps 32'hFFFF_FFFC → 0), → FETCH.
- HALTED: no requests, `inst_valid`=0; left only by reset.
- FAULT: see Configuration; left only by reset.
- `redirect_valid`/`halt` outside the consume cycle have no effect.
- One outstanding request maximum; no speculative fetch.

## Timing
- Reset values (while `rst`=1 and in the cycle after release): pc=`RESET_PC`, state=IDLE, `imem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fault`=0.
- Asserting `rst` in any state (including WAIT with a request in flight) immediately returns to IDLE. No response is expected after reset, because memory resets too.
- First request: 1 cycle after `rst` deasserts.
- Throughput with `imem_req_ready`=1, 1-cycle memory, and `inst_ready`=1: FETCH→WAIT→HOLD, i.e. 1 instruction per 3 cycles; `inst_valid` rises 2 cycles after request acceptance.
- All outputs are registered or decoded only from state/registers; no combinational path from any input to any output.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: on a consume with `redirect_valid`=1 and `redirect_pc[1:0]`≠0, → FAULT. `fault`=1 (registered, sticky), no further requests, `inst_valid`=0.
- Not defined: target is forced to `{redirect_pc[31:2],2'b00}`, the FAULT state is absent, and `fault`=0 constant.

## Test plan
- Reset release, `imem_req_ready`=1, memory returns 32'h00000013 each read, `inst_ready`=1 → request addrs 0x80000000, 0x80000004, 0x80000008 at cycles 1, 4, 7.
- `imem_req_ready` held low 5 cycles → `imem_req_valid`=1 with addr stable 0x80000000 all 5 cycles; a single WAIT after acceptance.
- `inst_ready` low 4 cycles in HOLD → `inst`/`inst_pc` unchanged, no new request until consume.
- Consume with `redirect_valid`=1, `redirect_pc`=0x80000100 → next request addr 0x80000100. `redirect_valid` pulsed while in WAIT → ignored, next addr is PC+4.
- Consume with `halt`=1 and `redirect_valid`=1 → HALTED, no further requests for 20 cycles, `inst_valid`=0.
- With macro: redirect to 0x80000102 → `fault`=1 next cycle, no requests. Without macro: next request addr 0x80000100. Separately, assert `rst` mid-WAIT → next request addr 0x80000000 one cycle after release.
